// File: rtl/mdu_iterative.sv
// -----------------------------------------------------------------------------
// mdu_iterative
//
// Iterative RV32M/RV64M multiply/divide unit for the kianv multicycle core.
// Works out one result bit per clock. Multiply is shift-add and divide is
// restoring. Signed operations run on operand magnitudes, and the result is
// negated when the unit enters DONE.
//
// Ports
//   clk     in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   valid   in   request strobe, sampled only in IDLE
//   funct3  in   [2:0] M-op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1     in   [XLEN-1:0] multiplicand / dividend
//   rs2     in   [XLEN-1:0] multiplier / divisor
//   busy    out  high in every non-IDLE state
//   ready   out  one-cycle pulse, rd is valid
//   rd      out  [XLEN-1:0] result, held until the next completed op
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for valid; operands, signs and special results latched
// CALC  | one iteration per clock; cnt counts down to 0
// DONE  | ready pulse; rd was loaded on the edge into this state
// -----------------------------------------------------------------------------
module mdu_iterative #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] rd
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                spec_q, spec_d;
    logic [XLEN-1:0]     spec_res_q, spec_res_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     rd_q, rd_d;

    // Decode of the incoming request, used only on the accept edge.
    logic            in_sign_a, in_sign_b;
    logic            in_neg_a, in_neg_b, in_neg_res;
    logic [XLEN-1:0] in_mag_a, in_mag_b;
    logic            in_div0, in_ovf, in_special;
    logic [XLEN-1:0] in_spec_res;

    always_comb begin
        in_sign_a  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
        in_sign_b  = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                     (funct3 == 3'b110);
        in_neg_a   = in_sign_a && rs1[XLEN-1];
        in_neg_b   = in_sign_b && rs2[XLEN-1];
        in_mag_a   = in_neg_a ? -rs1 : rs1;
        in_mag_b   = in_neg_b ? -rs2 : rs2;
        // The remainder takes the dividend's sign. Every other signed
        // result takes the xor of the two operand signs.
        in_neg_res = (funct3 == 3'b110) ? in_neg_a : (in_neg_a ^ in_neg_b);

        in_div0    = funct3[2] && (rs2 == '0);
        in_ovf     = funct3[2] && !funct3[0] && (rs1 == MOST_NEG) && (rs2 == ALL_ONES);
        in_special = in_div0 || in_ovf;
        if (in_div0) begin
            in_spec_res = funct3[1] ? rs1 : ALL_ONES;
        end else begin
            in_spec_res = funct3[1] ? '0 : rs1;
        end
    end

    // One iteration step. For both algorithms prod_q holds the running value:
    //   multiply: {partial product high, remaining multiplier bits}
    //   divide:   {partial remainder, dividend bits / quotient bits}
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] iter_next;

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, prod_q[XLEN-1:1]};

        // The shifted remainder is below 2*divisor, so bit XLEN of the
        // (XLEN+1)-bit difference is set exactly when the subtract borrows.
        div_shift = prod_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end

        iter_next = op_q[2] ? div_next : mul_next;
    end

    // Final result, taken from the value the last iteration is about to
    // store, so that rd is ready on the same edge that enters DONE.
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   res_hi, res_lo;
    logic [XLEN-1:0]   calc_res;

    always_comb begin
        res_hi   = iter_next[2*XLEN-1:XLEN];
        res_lo   = iter_next[XLEN-1:0];
        prod_neg = -iter_next;
        case (op_q)
            3'b000:                calc_res = res_lo;
            3'b001, 3'b010, 3'b011: calc_res = neg_q ? prod_neg[2*XLEN-1:XLEN] : res_hi;
            3'b100, 3'b101:        calc_res = neg_q ? -res_lo : res_lo;
            default:               calc_res = neg_q ? -res_hi : res_hi;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        opnd_d     = opnd_q;
        prod_d     = prod_q;
        rd_d       = rd_q;

        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    op_d       = funct3;
                    neg_d      = in_neg_res;
                    spec_d     = in_special;
                    spec_res_d = in_spec_res;
                    if (funct3[2]) begin
                        opnd_d = in_mag_b;
                        prod_d = {{XLEN{1'b0}}, in_mag_a};
                    end else begin
                        opnd_d = in_mag_a;
                        prod_d = {{XLEN{1'b0}}, in_mag_b};
                    end
                    if (in_special && FAST_SPECIAL) begin
                        state_d = S_DONE;
                        rd_d    = in_spec_res;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_CALC: begin
                prod_d = iter_next;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    // Special cases still run the full iteration when the
                    // fast path is off, but the stored result wins.
                    rd_d    = spec_q ? spec_res_q : calc_res;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            opnd_q     <= '0;
            prod_q     <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            opnd_q     <= opnd_d;
            prod_q     <= prod_d;
            rd_q       <= rd_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign ready = (state_q == S_DONE);
    assign rd    = rd_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// -----------------------------------------------------------------------------
// tb_mdu_iterative
//
// Directed bench for mdu_iterative. One instance has the fast special-case
// path enabled (suffix _f) and one has it disabled (suffix _s). The two
// instances share the operand buses and the reset, and each has its own
// valid input.
// -----------------------------------------------------------------------------
module tb_mdu_iterative;

    localparam int XLEN = 32;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic            clk = 1'b0;
    logic            resetn;
    logic            valid_f, valid_s;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1, rs2;
    logic            busy_f, ready_f, busy_s, ready_s;
    logic [XLEN-1:0] rd_f, rd_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_iterative #(.XLEN(XLEN), .FAST_SPECIAL(1'b1)) dut_f (
        .clk(clk), .resetn(resetn), .valid(valid_f), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .busy(busy_f), .ready(ready_f), .rd(rd_f)
    );

    mdu_iterative #(.XLEN(XLEN), .FAST_SPECIAL(1'b0)) dut_s (
        .clk(clk), .resetn(resetn), .valid(valid_s), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .busy(busy_s), .ready(ready_s), .rd(rd_s)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after the accept edge. lat is the count of edges,
    // with the accept edge counted, up to the first sample where ready is high.
    task automatic wait_ready(input bit slow, input bit scramble, output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (lat <= 100) begin
            if (slow ? busy_s : busy_f) bcnt++;
            if (slow ? ready_s : ready_f) break;
            if (scramble) begin
                rs1    = $urandom;
                rs2    = $urandom;
                funct3 = 3'($urandom_range(0, 7));
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input bit slow, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd,
                          input int exp_lat, input string tag);
        int lat;
        int bcnt;
        @(negedge clk);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        if (slow) valid_s = 1'b1;
        else      valid_f = 1'b1;
        @(posedge clk); #1;
        valid_f = 1'b0;
        valid_s = 1'b0;
        wait_ready(slow, 1'b0, lat, bcnt);
        chk({tag, ".lat"},  64'(lat), 64'(exp_lat));
        chk({tag, ".rd"},   64'(slow ? rd_s : rd_f), 64'(exp_rd));
        chk({tag, ".busy"}, 64'(bcnt), 64'(exp_lat));
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 64'(slow ? {ready_s, busy_s} : {ready_f, busy_f}), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    initial begin
        int  lat;
        int  bcnt;
        bit  saw;

        resetn  = 1'b1;
        valid_f = 1'b0;
        valid_s = 1'b0;
        funct3  = '0;
        rs1     = '0;
        rs2     = '0;
        #2 resetn = 1'b0;

        // Reset state, then idle with no requests.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.f", 64'({busy_f, ready_f, rd_f}), 64'(0));
        chk("rst.s", 64'({busy_s, ready_s, rd_s}), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (busy_f || ready_f || busy_s || ready_s || rd_f != '0 || rd_s != '0) saw = 1'b1;
        end
        chk("idle.quiet", 64'(saw), 64'(0));

        // Basic multiplies.
        run_op(0, F_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        run_op(0, F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
        run_op(0, F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        run_op(0, F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
        run_op(0, F_MULH,   32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 33, "mulh_neg");

        // Divides with mixed signs.
        run_op(0, F_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div");
        run_op(0, F_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem");
        run_op(0, F_DIVU, 32'd100,       32'd7,         32'd14,        33, "divu");
        run_op(0, F_REMU, 32'd100,       32'd7,         32'd2,         33, "remu");
        run_op(0, F_DIV,  32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, 33, "div_nb");
        run_op(0, F_REM,  32'd20,        32'hFFFF_FFFA, 32'd2,         33, "rem_nb");

        // Special cases, fast path.
        run_op(0, F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "f.divu0");
        run_op(0, F_REM,  32'd5,         32'd0,         32'd5,         1, "f.rem0");
        run_op(0, F_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1, "f.div0neg");
        run_op(0, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "f.divovf");
        run_op(0, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "f.removf");

        // Same special cases with the full iterative latency.
        run_op(1, F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 33, "s.divu0");
        run_op(1, F_REM,  32'd5,         32'd0,         32'd5,         33, "s.rem0");
        run_op(1, F_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 33, "s.div0neg");
        run_op(1, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "s.divovf");
        run_op(1, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, "s.removf");

        // valid held high while operands keep changing.
        @(negedge clk);
        funct3  = F_DIVU;
        rs1     = 32'd100;
        rs2     = 32'd7;
        valid_f = 1'b1;
        @(posedge clk); #1;
        wait_ready(0, 1'b1, lat, bcnt);
        chk("hs.lat", 64'(lat), 64'(33));
        chk("hs.rd",  64'(rd_f), 64'(14));
        funct3 = F_MULHU;
        rs1    = 32'hFFFF_FFFF;
        rs2    = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("hs.idle", 64'(busy_f), 64'(0));
        @(posedge clk); #1;
        chk("hs.acc", 64'(busy_f), 64'(1));
        valid_f = 1'b0;
        wait_ready(0, 1'b0, lat, bcnt);
        chk("hs2.lat", 64'(lat), 64'(33));
        chk("hs2.rd",  64'(rd_f), 64'(32'hFFFF_FFFE));
        @(posedge clk); #1;

        // Back-to-back: the second op is accepted at the end of the IDLE
        // cycle that follows the first ready pulse.
        run_op(0, F_MUL,  32'd12345,     32'd678,       32'd8369910,   33, "b2b.mul");
        run_op(0, F_DIVU, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 33, "b2b.divu");

        // Reset asserted during CALC cycle 10 of a DIV.
        @(negedge clk);
        funct3  = F_DIV;
        rs1     = 32'hFFFF_FFF9;
        rs2     = 32'd2;
        valid_f = 1'b1;
        @(posedge clk); #1;
        valid_f = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("mid.busy_pre", 64'(busy_f), 64'(1));
        resetn = 1'b0;
        #1;
        chk("mid.rst", 64'({busy_f, ready_f, rd_f}), 64'(0));
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ready_f || busy_f) saw = 1'b1;
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (ready_f || busy_f) saw = 1'b1;
        end
        chk("mid.noready", 64'(saw), 64'(0));
        chk("mid.rd", 64'(rd_f), 64'(0));
        run_op(0, F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised, iterative RV32M/RV64M multiply/divide unit for the kianv multicycle core.
- Decodes funct3 of an OP/OP-32 M-extension instruction and computes the result one bit per cycle (shift-add multiply, restoring divide).
- Uses a valid/ready handshake so the control FSM can stall in its execute state.
- Sits beside the ALU; its result is muxed into the writeback path.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- FAST_SPECIAL, 1, if 1 then divide-by-zero and signed overflow complete in 1 cycle; if 0 they take the full iterative latency with the same results.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- valid  input  1  request strobe; sampled only in IDLE.
- funct3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  XLEN  operand A (multiplicand/dividend).
- rs2  input  XLEN  operand B (multiplier/divisor).
- busy  output  1  high in every non-IDLE state.
- ready  output  1  one-cycle pulse: rd is valid.
- rd  output  XLEN  result; holds its value until the next accept.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, busy=0, ready=0, rd=0, all internal registers 0. Reset asserted mid-operation aborts the op with no ready pulse.
- States:
  - IDLE: on valid=1, latch funct3 and the operand magnitudes/signs. Go to DONE if this is an FAST_SPECIAL case, otherwise go to CALC with cnt=XLEN-1.
  - CALC: one iteration per edge. When cnt==0, go to DONE; otherwise decrement cnt.
  - DONE: ready=1 and rd is updated on entry. Return to IDLE on the next edge.
- Latency, counted as edges after the accept edge until ready is high:
  - normal ops: XLEN+1;
  - fast special cases: 1.
- Back-to-back: the next request can be accepted in the cycle after the ready pulse (IDLE). valid while busy=1 is ignored and never queued.
- Operand signedness:
  - MULH: signed x signed.
  - MULHSU: signed rs1 x unsigned rs2.
  - MULHU, DIVU, REMU: unsigned.
  - MUL: low half, sign-agnostic.
  - DIV, REM: signed.
- Signed handling: take the absolute values, run the unsigned iteration, then conditionally two's-complement negate the result in DONE.
  - Product sign = sA^sB.
  - Quotient sign = sA^sB.
  - Remainder sign = sA.
- Multiply:
  - 2*XLEN product register; each CALC cycle adds the multiplicand when the current multiplier LSB is 1, then shifts right.
  - MUL returns product[XLEN-1:0]; the MULH* ops return product[2*XLEN-1:XLEN] after sign correction on the full 2*XLEN value.
- Divide: restoring algorithm. Each CALC cycle shifts {rem,quot} left by 1, does a trial subtract of the divisor, and sets the quotient bit when the subtract does not underflow.
- Special cases (RISC-V spec, no exception):
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give rs1.
  - Signed overflow (rs1 = most negative, rs2 = -1, DIV/REM only): DIV gives rs1; REM gives 0.
- Arithmetic wraps modulo 2^XLEN (2^(2*XLEN) for the product). The intermediate subtract is XLEN+1 bits wide to detect the borrow.
- rd changes only on entry to DONE. busy and ready are registered (decoded from the state register), with no combinational path from valid.

Test Plan:
- Reset then idle: resetn 0→1 with no valid → busy=0, ready=0, rd=0 indefinitely. Then MUL rs1=7, rs2=0xFFFFFFFD → ready exactly 33 edges after accept, rd=0xFFFFFFEB, busy high for 33 cycles.
- High multiplies:
  - MULH 0x80000000 x 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- Special cases with FAST_SPECIAL=1, each with ready 1 edge after accept:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
  - Repeat with FAST_SPECIAL=0 → identical rd, ready after 33 edges.
- Handshake:
  - Hold valid high continuously with changing operands → each accept only in IDLE; mid-op operand changes do not affect rd.
  - Back-to-back MUL then DIVU → second accepted on the edge after the first ready pulse.
- Reset mid-op: assert resetn=0 at CALC cycle 10 of a DIV → busy=0, ready never pulses, rd=0. A new request after release completes correctly.
